// File: rtl/irq_controller.sv
// Fixed-priority interrupt controller: masks requests with MIE, grants the lowest index, and holds it through the handler.
// int_o rises one cycle after the request is sampled; no backpressure, the grant waits in PEND until the core takes it.
module irq_controller #(
    parameter int N_IRQ = 32,
    parameter int ID_W  = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_IRQ-1:0] int_req_i,
    input  logic [N_IRQ-1:0] mie_i,
    input  logic             int_taken_i,
    input  logic             int_rst_i,
    output logic             int_o,
    output logic [31:0]      mcause_o,
    output logic [N_IRQ-1:0] int_fin_o,
    output logic             busy_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PEND = 2'd1;
    localparam logic [1:0] ST_SERV = 2'd2;
    localparam logic [1:0] ST_FIN  = 2'd3;

    localparam logic [N_IRQ-1:0] LP_ONE = N_IRQ'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [ID_W-1:0]  r_id;
    logic [ID_W-1:0]  w_win_id;
    logic [N_IRQ-1:0] w_masked;
    logic             w_any;

    assign w_masked = int_req_i & mie_i;
    assign w_any    = |w_masked;

    // Descending scan so the lowest set index is the last to assign.
    always_comb begin
        w_win_id = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (w_masked[i]) begin
                w_win_id = ID_W'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_any)       w_state_nxt = ST_PEND;
            ST_PEND: if (int_taken_i) w_state_nxt = ST_SERV;
            ST_SERV: if (int_rst_i)   w_state_nxt = ST_FIN;
            ST_FIN:                   w_state_nxt = ST_IDLE;
            default:                  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_id    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && w_any) begin
                r_id <= w_win_id;
            end
        end
    end

    assign int_o     = (r_state == ST_PEND);
    assign busy_o    = (r_state != ST_IDLE);
    assign int_fin_o = (r_state == ST_FIN) ? (LP_ONE << r_id) : '0;

    // Cause stays visible through the handler and is cleared on the completion cycle.
    always_comb begin
        mcause_o = '0;
        if (r_state == ST_PEND || r_state == ST_SERV) begin
            mcause_o[31]       = 1'b1;
            mcause_o[ID_W-1:0] = r_id;
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Randomised scoreboard bench for irq_controller: a driver pushes expected events, a negedge monitor pops and compares them.
module tb_irq_controller;

    localparam int EV_GRANT = 0;
    localparam int EV_TAKE  = 1;
    localparam int EV_FIN   = 2;
    localparam int EV_IDLE  = 3;

    typedef struct {
        int          kind;
        logic [31:0] val;
        int          cyc;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] int_req_i;
    logic [31:0] mie_i;
    logic        int_taken_i;
    logic        int_rst_i;
    logic        int_o;
    logic [31:0] mcause_o;
    logic [31:0] int_fin_o;
    logic        busy_o;

    irq_controller #(.N_IRQ(32), .ID_W(5)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .int_req_i   (int_req_i),
        .mie_i       (mie_i),
        .int_taken_i (int_taken_i),
        .int_rst_i   (int_rst_i),
        .int_o       (int_o),
        .mcause_o    (mcause_o),
        .int_fin_o   (int_fin_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int    cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    exp_t  sb[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    bit    mon_en = 1'b0;
    logic  p_int = 1'b0;
    logic  p_busy = 1'b0;
    string ev_name [4] = '{"grant", "take", "fin", "idle"};

    // Reference: index of the lowest set bit, via isolating it arithmetically.
    function automatic int lowest(input logic [31:0] m);
        logic [31:0] iso;
        iso = m & (~m + 32'd1);
        return $clog2(iso);
    endfunction

    task automatic push(input int k, input logic [31:0] v, input int c);
        exp_t e;
        e.kind = k;
        e.val  = v;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    task automatic check_evt(input int k, input logic [31:0] v);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_%s: got val=%h at cyc %0d, required no event", ev_name[k], v, cyc);
        end else begin
            e = sb.pop_front();
            if (e.kind != k || e.val !== v || e.cyc != cyc) begin
                n_bad++;
                $display("FAIL %s: got %s val=%h cyc=%0d, required %s val=%h cyc=%0d",
                         ev_name[e.kind], ev_name[k], v, cyc, ev_name[e.kind], e.val, e.cyc);
            end
        end
    endtask

    task automatic flush_stale();
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missing_%s: got no event by cyc %0d, required val=%h at cyc %0d",
                     ev_name[e.kind], cyc, e.val, e.cyc);
        end
    endtask

    always @(negedge clk_i) begin
        if (mon_en) begin
            if (int_o === 1'b1 && p_int === 1'b0) check_evt(EV_GRANT, mcause_o);
            if (int_o === 1'b0 && p_int === 1'b1) check_evt(EV_TAKE, mcause_o);
            if (int_fin_o !== 32'h0)              check_evt(EV_FIN, int_fin_o);
            if (busy_o === 1'b0 && p_busy === 1'b1)
                check_evt(EV_IDLE, mcause_o | int_fin_o | {31'h0, int_o});
            flush_stale();
            p_int  = int_o;
            p_busy = busy_o;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_zero(input string name);
        n_cmp++;
        if (int_o !== 1'b0 || mcause_o !== 32'h0 || int_fin_o !== 32'h0 || busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL %s: got int=%b mcause=%h fin=%h busy=%b, required all zero",
                     name, int_o, mcause_o, int_fin_o, busy_o);
        end
    endtask

    // Full transaction; entered with the DUT idle and returns with it idle again.
    task automatic do_txn(input logic [31:0] req, input logic [31:0] mie, input int pw, input int sw,
                          input bit both, input bit keep, input bit disturb);
        logic [31:0] cause;
        int          idx;
        idx   = lowest(req & mie);
        cause = 32'h8000_0000 | 32'(idx);
        int_req_i = req;
        mie_i     = mie;
        push(EV_GRANT, cause, cyc + 1);
        tick();
        for (int i = 0; i < pw; i++) begin
            if (disturb) begin
                int_req_i = $urandom | 32'h1;
                mie_i     = $urandom | 32'h1;
            end
            tick();
        end
        int_taken_i = 1'b1;
        int_rst_i   = both;
        push(EV_TAKE, cause, cyc + 1);
        tick();
        int_taken_i = 1'b0;
        int_rst_i   = 1'b0;
        for (int i = 0; i < sw; i++) begin
            int_taken_i = 1'($urandom_range(0, 1));
            tick();
        end
        int_req_i = keep ? req : 32'h0;
        mie_i     = mie;
        int_rst_i = 1'b1;
        push(EV_FIN, 32'h1 << idx, cyc + 1);
        push(EV_IDLE, 32'h0, cyc + 2);
        tick();
        int_rst_i   = 1'b0;
        int_taken_i = 1'($urandom_range(0, 1));
        tick();
        int_taken_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish by time %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rq;
        logic [31:0] mk;
        bit          keep;
        int          b;

        rst_i       = 1'b1;
        int_req_i   = 32'hFFFF_FFFF;
        mie_i       = 32'hFFFF_FFFF;
        int_taken_i = 1'b1;
        int_rst_i   = 1'b1;
        repeat (3) tick();
        check_zero("reset_state");
        int_req_i   = 32'h0;
        mie_i       = 32'h0;
        int_taken_i = 1'b0;
        int_rst_i   = 1'b0;
        rst_i       = 1'b0;
        mon_en      = 1'b1;
        tick();
        check_zero("idle_after_reset");

        do_txn(32'h0000_0010, 32'hFFFF_FFFF, 2, 2, 1'b0, 1'b0, 1'b0);
        check_zero("idle_after_txn1");
        do_txn(32'h8000_0006, 32'hFFFF_FFFF, 1, 1, 1'b0, 1'b0, 1'b0);
        do_txn(32'h8000_0004, 32'hFFFF_FFFF, 1, 1, 1'b0, 1'b0, 1'b0);

        // All requests masked: nothing may be raised.
        int_req_i = 32'hFFFF_FFFF;
        mie_i     = 32'h0;
        repeat (50) tick();
        do_txn(32'hFFFF_FFFF, 32'h0000_0100, 0, 0, 1'b0, 1'b0, 1'b0);

        do_txn(32'h0000_0008, 32'hFFFF_FFFF, 3, 1, 1'b0, 1'b0, 1'b1);

        // Reset in SERV aborts without a completion pulse; a later mret is stray.
        int_req_i = 32'h0000_0020;
        mie_i     = 32'hFFFF_FFFF;
        push(EV_GRANT, 32'h8000_0005, cyc + 1);
        tick();
        int_taken_i = 1'b1;
        push(EV_TAKE, 32'h8000_0005, cyc + 1);
        tick();
        int_taken_i = 1'b0;
        tick();
        rst_i     = 1'b1;
        int_req_i = 32'h0;
        push(EV_IDLE, 32'h0, cyc + 1);
        tick();
        rst_i = 1'b0;
        check_zero("rst_mid_serv");
        tick();
        int_rst_i = 1'b1;
        tick();
        int_rst_i = 1'b0;
        repeat (3) tick();
        check_zero("stray_rst_after_abort");

        int_rst_i = 1'b1;
        tick();
        int_rst_i   = 1'b0;
        int_taken_i = 1'b1;
        tick();
        int_taken_i = 1'b0;
        tick();
        do_txn(32'h0000_0400, 32'hFFFF_FFFF, 1, 2, 1'b1, 1'b0, 1'b0);

        // Request left high through completion is granted again after one idle cycle.
        do_txn(32'h0000_0002, 32'hFFFF_FFFF, 0, 0, 1'b0, 1'b1, 1'b0);
        do_txn(32'h0000_0002, 32'hFFFF_FFFF, 0, 0, 1'b0, 1'b0, 1'b0);

        keep = 1'b0;
        rq   = 32'h0;
        mk   = 32'h0;
        for (int t = 0; t < 40; t++) begin
            if (!keep) begin
                if ($urandom_range(0, 2) == 0) begin
                    rq        = $urandom;
                    int_req_i = rq;
                    mie_i     = ~rq;
                    repeat ($urandom_range(1, 4)) tick();
                end
                rq = $urandom;
                mk = $urandom;
                if ($urandom_range(0, 1) == 1) rq = rq & (32'hFFFF_FFFF << $urandom_range(0, 31));
                if ((rq & mk) == 32'h0) begin
                    b     = int'($urandom_range(0, 31));
                    rq[b] = 1'b1;
                    mk[b] = 1'b1;
                end
            end
            keep = (t < 39) && ($urandom_range(0, 4) == 0);
            do_txn(rq, mk, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 3) == 0), keep, 1'($urandom_range(0, 1)));
        end

        repeat (5) tick();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d outstanding events, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
